// File: rtl/common_types_pkg.sv
// Shared control-path types for the core pipeline.
package common_types_pkg;

  typedef enum logic [1:0] {
    PC_NONE   = 2'd0,
    PC_BRANCH = 2'd1,
    PC_TRAP   = 2'd2
  } pc_redirect_t;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MULT_WAIT = 2'd1,
    HALTED    = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/mult_occupancy_cnt.sv
// Down-counter tracking the remaining busy cycles of an issued multiply.
module mult_occupancy_cnt #(
  parameter int MULT_LATENCY = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic load,
  input  logic dec,
  output logic done
);

  // The issue cycle is the first occupancy cycle, so the wait phase counts ML-2 down to 0.
  localparam int LOAD_VAL = (MULT_LATENCY > 1) ? MULT_LATENCY - 2 : 0;
  localparam int CW       = (MULT_LATENCY > 2) ? $clog2(MULT_LATENCY - 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LOAD_VAL);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: latch enables, flushes, PC control,
// multiplier occupancy and a stall-cycle performance counter.
module pipeline_hazard_ctrl
  import common_types_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_dread,
  input  logic             ex_mult,
  input  logic             ex_mispredict,
  input  logic             ex_illegal,
  input  logic             ex_halt,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  output logic             pc_en,
  output logic [1:0]       pc_redirect,
  output logic             f2d_en,
  output logic             f2d_flush,
  output logic             d2e_en,
  output logic             d2e_flush,
  output logic             e2m_en,
  output logic             e2m_flush,
  output logic             mult_start,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  hazard_state_t state, state_nxt;
  pc_redirect_t  redirect;
  logic          mult_done;
  logic          mult_issue;
  logic          load_use;
  logic          resolving;

  assign load_use = ex_dread && (ex_rd != 5'd0) &&
                    ((dec_use_rs1 && (dec_rs1 == ex_rd)) ||
                     (dec_use_rs2 && (dec_rs2 == ex_rd)));

  assign mult_issue = (state == RUN) && ex_mult && (MULT_LATENCY > 1) &&
                      !(ex_halt || ex_illegal || ex_mispredict || dmem_wait);

  // Cycles where the priority table decides the enables: all of RUN plus the last wait cycle.
  assign resolving = (state == RUN) || ((state == MULT_WAIT) && mult_done);

  mult_occupancy_cnt #(
    .MULT_LATENCY (MULT_LATENCY)
  ) u_mult_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .load (mult_issue),
    .dec  (state == MULT_WAIT),
    .done (mult_done)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (ex_halt) begin
          state_nxt = HALTED;
        end else if (mult_issue) begin
          state_nxt = MULT_WAIT;
        end
      end
      MULT_WAIT: begin
        if (mult_done) begin
          if (ex_halt) begin
            state_nxt = HALTED;
          end else if (ex_illegal || ex_mispredict || !dmem_wait) begin
            state_nxt = RUN;
          end
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    f2d_en     = 1'b0;
    f2d_flush  = 1'b0;
    d2e_en     = 1'b0;
    d2e_flush  = 1'b0;
    e2m_en     = 1'b0;
    e2m_flush  = 1'b0;
    redirect   = PC_NONE;
    mult_start = 1'b0;
    if (nRST && resolving) begin
      if (ex_halt) begin
        f2d_en    = 1'b1;
        f2d_flush = 1'b1;
        d2e_en    = 1'b1;
        d2e_flush = 1'b1;
        e2m_en    = 1'b1;
      end else if (ex_illegal) begin
        pc_en     = 1'b1;
        f2d_en    = 1'b1;
        f2d_flush = 1'b1;
        d2e_en    = 1'b1;
        d2e_flush = 1'b1;
        e2m_en    = 1'b1;
        e2m_flush = 1'b1;
        redirect  = PC_TRAP;
      end else if (ex_mispredict) begin
        pc_en     = 1'b1;
        f2d_en    = 1'b1;
        f2d_flush = 1'b1;
        d2e_en    = 1'b1;
        d2e_flush = 1'b1;
        e2m_en    = 1'b1;
        redirect  = PC_BRANCH;
      end else if (dmem_wait) begin
        pc_en = 1'b0;
      end else if (mult_issue) begin
        mult_start = 1'b1;
      end else begin
        // Single-cycle multiplier: pulse only, the instruction flows on unstalled.
        mult_start = (state == RUN) && ex_mult;
        if (load_use) begin
          d2e_en    = 1'b1;
          d2e_flush = 1'b1;
          e2m_en    = 1'b1;
        end else if (imem_wait) begin
          f2d_en    = 1'b1;
          f2d_flush = 1'b1;
          d2e_en    = 1'b1;
          e2m_en    = 1'b1;
        end else if (state == RUN) begin
          pc_en  = 1'b1;
          f2d_en = 1'b1;
          d2e_en = 1'b1;
          e2m_en = 1'b1;
        end else begin
          e2m_en = 1'b1;
        end
      end
    end
  end

  assign pc_redirect = redirect;
  assign halted      = (state == HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (!pc_en && (state != HALTED)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with MULT_LATENCY = 4.
module tb_pipeline_hazard_ctrl;

  // Control vector order: pc_en, f2d_en, f2d_flush, d2e_en, d2e_flush, e2m_en, e2m_flush, pc_redirect[1:0], mult_start
  localparam logic [9:0] C_ZERO    = 10'b0_0_0_0_0_0_0_00_0;
  localparam logic [9:0] C_IDLE    = 10'b1_1_0_1_0_1_0_00_0;
  localparam logic [9:0] C_LOADUSE = 10'b0_0_0_1_1_1_0_00_0;
  localparam logic [9:0] C_IMEM    = 10'b0_1_1_1_0_1_0_00_0;
  localparam logic [9:0] C_MISPRED = 10'b1_1_1_1_1_1_0_01_0;
  localparam logic [9:0] C_ILLEGAL = 10'b1_1_1_1_1_1_1_10_0;
  localparam logic [9:0] C_HALT    = 10'b0_1_1_1_1_1_0_00_0;
  localparam logic [9:0] C_MISSUE  = 10'b0_0_0_0_0_0_0_00_1;
  localparam logic [9:0] C_MFINAL  = 10'b0_0_0_0_0_1_0_00_0;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [4:0]  dec_rs1, dec_rs2, ex_rd;
  logic        dec_use_rs1, dec_use_rs2;
  logic        ex_dread, ex_mult, ex_mispredict, ex_illegal, ex_halt;
  logic        imem_wait, dmem_wait;
  logic        pc_en, f2d_en, f2d_flush, d2e_en, d2e_flush, e2m_en, e2m_flush;
  logic        mult_start, halted;
  logic [1:0]  pc_redirect;
  logic [31:0] stall_cnt;
  logic [9:0]  ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_en, f2d_en, f2d_flush, d2e_en, d2e_flush, e2m_en, e2m_flush, pc_redirect, mult_start};

  pipeline_hazard_ctrl #(.MULT_LATENCY(4), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .ex_rd(ex_rd), .ex_dread(ex_dread), .ex_mult(ex_mult), .ex_mispredict(ex_mispredict),
    .ex_illegal(ex_illegal), .ex_halt(ex_halt), .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .f2d_en(f2d_en), .f2d_flush(f2d_flush),
    .d2e_en(d2e_en), .d2e_flush(d2e_flush), .e2m_en(e2m_en), .e2m_flush(e2m_flush),
    .mult_start(mult_start), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; ex_rd = 5'd0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
    ex_dread = 1'b0; ex_mult = 1'b0; ex_mispredict = 1'b0; ex_illegal = 1'b0; ex_halt = 1'b0;
    imem_wait = 1'b0; dmem_wait = 1'b0;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    clear_inputs();
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clear_inputs();
    tick();
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_ZERO); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    nRST = 1'b1;
    #4;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL idle_ctl: got %b expected %b", ctl, C_IDLE); end
    tick();
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL idle_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_dread = 1'b1; ex_rd = 5'd5; dec_rs2 = 5'd5; dec_use_rs2 = 1'b1;
    #4;
    checks++; if (ctl !== C_LOADUSE) begin errors++; $display("FAIL loaduse_rs2_ctl: got %b expected %b", ctl, C_LOADUSE); end
    tick();
    clear_inputs();
    #4;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL loaduse_one_bubble: got %b expected %b", ctl, C_IDLE); end
    tick();
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL loaduse_stall_cnt: got %0d expected 1", stall_cnt); end
    ex_dread = 1'b1; ex_rd = 5'd0; dec_rs2 = 5'd0; dec_use_rs2 = 1'b1; dec_rs1 = 5'd0; dec_use_rs1 = 1'b1;
    #4;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL loaduse_rd0_ctl: got %b expected %b", ctl, C_IDLE); end
    tick();
    clear_inputs();
    ex_dread = 1'b1; ex_rd = 5'd9; dec_rs1 = 5'd9; dec_use_rs1 = 1'b1;
    #4;
    checks++; if (ctl !== C_LOADUSE) begin errors++; $display("FAIL loaduse_rs1_ctl: got %b expected %b", ctl, C_LOADUSE); end
    tick();
    clear_inputs();
    ex_dread = 1'b1; ex_rd = 5'd7; dec_rs2 = 5'd7; dec_use_rs2 = 1'b0;
    #4;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL loaduse_unused_src_ctl: got %b expected %b", ctl, C_IDLE); end
    tick();
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL loaduse_stall_cnt2: got %0d expected 2", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_mult();
    int starts;
    apply_reset();
    starts = 0;
    ex_mult = 1'b1;
    #4;
    checks++; if (ctl !== C_MISSUE) begin errors++; $display("FAIL mult_issue_ctl: got %b expected %b", ctl, C_MISSUE); end
    starts += int'(mult_start);
    for (int i = 1; i <= 2; i++) begin
      tick();
      #4;
      checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL mult_wait_ctl cycle %0d: got %b expected %b", i, ctl, C_ZERO); end
      starts += int'(mult_start);
    end
    tick();
    #4;
    checks++; if (ctl !== C_MFINAL) begin errors++; $display("FAIL mult_final_ctl: got %b expected %b", ctl, C_MFINAL); end
    starts += int'(mult_start);
    tick();
    ex_mult = 1'b0;
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL mult_stall_cnt: got %0d expected 4", stall_cnt); end
    #4;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL mult_resume_ctl: got %b expected %b", ctl, C_IDLE); end
    checks++; if (starts !== 1) begin errors++; $display("FAIL mult_start_pulses: got %0d expected 1", starts); end
    tick();
  endtask

  task automatic test_mispredict_imem();
    apply_reset();
    ex_mispredict = 1'b1; imem_wait = 1'b1;
    #4;
    checks++; if (ctl !== C_MISPRED) begin errors++; $display("FAIL mispred_imem_ctl: got %b expected %b", ctl, C_MISPRED); end
    tick();
    ex_mispredict = 1'b0;
    #4;
    checks++; if (ctl !== C_IMEM) begin errors++; $display("FAIL imem_only_ctl: got %b expected %b", ctl, C_IMEM); end
    tick();
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL imem_stall_cnt: got %0d expected 1", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_priority();
    apply_reset();
    ex_illegal = 1'b1; ex_mispredict = 1'b1;
    #4;
    checks++; if (ctl !== C_ILLEGAL) begin errors++; $display("FAIL prio_illegal_ctl: got %b expected %b", ctl, C_ILLEGAL); end
    tick();
    clear_inputs();
    dmem_wait = 1'b1; ex_dread = 1'b1; ex_rd = 5'd3; dec_rs1 = 5'd3; dec_use_rs1 = 1'b1; imem_wait = 1'b1;
    #4;
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL prio_dmem_freeze_ctl: got %b expected %b", ctl, C_ZERO); end
    tick();
    dmem_wait = 1'b0;
    #4;
    checks++; if (ctl !== C_LOADUSE) begin errors++; $display("FAIL prio_loaduse_over_imem: got %b expected %b", ctl, C_LOADUSE); end
    tick();
    clear_inputs();
  endtask

  task automatic test_dmem_during_mult();
    apply_reset();
    ex_mult = 1'b1;
    #4;
    checks++; if (ctl !== C_MISSUE) begin errors++; $display("FAIL dmult_issue_ctl: got %b expected %b", ctl, C_MISSUE); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      dmem_wait = 1'b1;
      #4;
      checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL dmult_freeze_ctl cycle %0d: got %b expected %b", i, ctl, C_ZERO); end
    end
    tick();
    dmem_wait = 1'b0;
    #4;
    checks++; if (ctl !== C_MFINAL) begin errors++; $display("FAIL dmult_release_ctl: got %b expected %b", ctl, C_MFINAL); end
    tick();
    ex_mult = 1'b0;
    checks++; if (stall_cnt !== 32'd7) begin errors++; $display("FAIL dmult_stall_cnt: got %0d expected 7", stall_cnt); end
    #4;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL dmult_resume_ctl: got %b expected %b", ctl, C_IDLE); end
    tick();
  endtask

  task automatic test_reset_mid_mult();
    apply_reset();
    ex_mult = 1'b1;
    tick();
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL midmult_reset_ctl: got %b expected %b", ctl, C_ZERO); end
    tick();
    #4;
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL midmult_in_reset_ctl: got %b expected %b", ctl, C_ZERO); end
    tick();
    nRST = 1'b1;
    ex_mult = 1'b0;
    #4;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL midmult_run_ctl: got %b expected %b", ctl, C_IDLE); end
    tick();
  endtask

  task automatic test_halt_reset();
    apply_reset();
    ex_halt = 1'b1;
    #4;
    checks++; if (ctl !== C_HALT) begin errors++; $display("FAIL halt_ctl: got %b expected %b", ctl, C_HALT); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_not_yet: got %b expected 0", halted); end
    tick();
    ex_halt = 1'b0; ex_illegal = 1'b1; ex_mispredict = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #4;
      checks++; if (halted !== 1'b1 || ctl !== C_ZERO) begin
        errors++; $display("FAIL halted_hold cycle %0d: got halted=%b ctl=%b expected halted=1 ctl=%b", i, halted, ctl, C_ZERO);
      end
      tick();
    end
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL halted_stall_cnt: got %0d expected 1", stall_cnt); end
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL async_reset_halted: got %b expected 0", halted); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL async_reset_stall_cnt: got %0d expected 0", stall_cnt); end
    tick();
    clear_inputs();
    nRST = 1'b1;
    #4;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL post_halt_run_ctl: got %b expected %b", ctl, C_IDLE); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mult();
    test_mispredict_imem();
    test_priority();
    test_dmem_during_mult();
    test_reset_mid_mult();
    test_halt_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
